// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the CPU memory responder: bus defaults, access encodings, FSM states.
// Optional feature macro: MEM_PARITY_EN (per-word even parity with sticky error flag).
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4096;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/cpu_memory_if.sv
// CPU-to-memory request/response bus. The CPU side is master, the memory is slave.
// Optional feature macro: MEM_PARITY_EN adds the parity_err response line.
interface cpu_memory_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              mem_en;
  logic              read_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              clr_mem;
  logic [DATA_W-1:0] data_out;
  logic              busy;
`ifdef MEM_PARITY_EN
  logic              parity_err;

  modport master (
    output mem_en, read_write, address, data_in, clr_mem,
    input  data_out, busy, parity_err
  );
  modport slave (
    input  mem_en, read_write, address, data_in, clr_mem,
    output data_out, busy, parity_err
  );
`else
  modport master (
    output mem_en, read_write, address, data_in, clr_mem,
    input  data_out, busy
  );
  modport slave (
    input  mem_en, read_write, address, data_in, clr_mem,
    output data_out, busy
  );
`endif

endinterface

// File: rtl/cpu_memory_mem_array.sv
// Synchronous single-port RAM with registered read; the read register holds when re is low.
// Word width is set by the parent (data plus parity bit when MEM_PARITY_EN is defined).
module mem_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cpu_memory.sv
// CPU memory responder: 1-cycle registered reads, writes, range check and a hardware clear sweep.
// Optional feature macro: MEM_PARITY_EN (even parity per word, sticky parity_err on read mismatch).
module cpu_memory
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  cpu_memory_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  state_t          state_reg;
  logic [AW-1:0]   clr_cnt_reg;
  logic            busy_reg;
  logic            zero_reg;
  logic            rd_valid_reg;

  logic            in_range;
  logic            access;
  logic            arr_we;
  logic            arr_re;
  logic [AW-1:0]   arr_addr;
  logic [MW-1:0]   arr_wdata;
  logic [MW-1:0]   arr_rdata;

  assign in_range = ({1'b0, bus.address} < (ADDR_W + 1)'(DEPTH));
  // A clear request in IDLE takes priority and swallows any access in the same cycle.
  assign access   = (state_reg == IDLE) && !bus.clr_mem && bus.mem_en;
  assign arr_re   = access && (bus.read_write == RD) && in_range;
  assign arr_we   = (state_reg == CLEAR) || (access && (bus.read_write == WR) && in_range);
  assign arr_addr = (state_reg == CLEAR) ? clr_cnt_reg : bus.address[AW-1:0];

`ifdef MEM_PARITY_EN
  assign arr_wdata = (state_reg == CLEAR) ? '0 : {^bus.data_in, bus.data_in};
`else
  assign arr_wdata = (state_reg == CLEAR) ? '0 : bus.data_in;
`endif

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (MW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      clr_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      zero_reg     <= 1'b1;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= arr_re;
      case (state_reg)
        IDLE: begin
          if (bus.clr_mem) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            zero_reg    <= 1'b1;
          end else if (access && (bus.read_write == RD)) begin
            // Out-of-range reads present zero instead of the stale RAM register.
            zero_reg <= !in_range;
          end
        end
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == AW'(DEPTH - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_reg <= 1'b0;
    end else if ((state_reg == IDLE) && bus.clr_mem) begin
      parity_err_reg <= 1'b0;
    end else if (rd_valid_reg && (^arr_rdata)) begin
      parity_err_reg <= 1'b1;
    end
  end

  assign bus.parity_err = parity_err_reg;
`endif

  assign bus.data_out = zero_reg ? '0 : arr_rdata[DATA_W-1:0];
  assign bus.busy     = busy_reg;

endmodule
